// File: rtl/m6502_pkg.sv
// Shared m6502 definitions: memory-controller FSM states, requester owners
// and the loader image base address.
package m6502_pkg;

    typedef enum logic [2:0] {
        MEMC_IDLE    = 3'd0,
        MEMC_ACCESS  = 3'd1,
        MEMC_WAIT    = 3'd2,
        MEMC_DONE    = 3'd3,
        MEMC_RELEASE = 3'd4
    } memc_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LD  = 1'b1
    } owner_e;

    localparam logic [15:0] BOOT_ADDR = 16'h0000;

endpackage

// File: rtl/m6502_mem_ctrl_if.sv
// Bus bundle for m6502_mem_ctrl: CPU port, boot-loader port and RAM port.
// The controller takes the slave view; the requesters/RAM model take master.
interface m6502_mem_ctrl_if;

    logic        cpu_cs;
    logic        cpu_wr;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_write_data;
    logic        cpu_mem_ready;
    logic        cpu_data_valid;
    logic [7:0]  cpu_read_data;

    logic        ld_req;
    logic        ld_wr;
    logic [15:0] ld_address;
    logic [7:0]  ld_write_data;
    logic        ld_ack;
    logic [7:0]  ld_read_data;

    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  cpu_cs, cpu_wr, cpu_address, cpu_write_data,
        input  ld_req, ld_wr, ld_address, ld_write_data,
        input  ram_rdata,
        output cpu_mem_ready, cpu_data_valid, cpu_read_data,
        output ld_ack, ld_read_data,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_cs, cpu_wr, cpu_address, cpu_write_data,
        output ld_req, ld_wr, ld_address, ld_write_data,
        output ram_rdata,
        input  cpu_mem_ready, cpu_data_valid, cpu_read_data,
        input  ld_ack, ld_read_data,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/m6502_mem_ctrl.sv
// Single-port RAM controller shared by the m6502 core and the boot loader,
// with round-robin arbitration and a configurable number of wait states.
module m6502_mem_ctrl
    import m6502_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    m6502_mem_ctrl_if.slave   bus
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    memc_state_e state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_owner_q, last_owner_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic        ld_ack_q, ld_ack_d;
    logic        grant_cpu;

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        cpu_ready_d  = 1'b0;
        cpu_valid_d  = 1'b0;
        ld_ack_d     = 1'b0;

        // On a tie the CPU wins unless it was the last one served.
        grant_cpu = bus.cpu_cs && (!bus.ld_req || (last_owner_q == OWNER_LD));

        case (state_q)
            MEMC_IDLE: begin
                if (bus.cpu_cs || bus.ld_req) begin
                    if (grant_cpu) begin
                        owner_d      = OWNER_CPU;
                        last_owner_d = OWNER_CPU;
                        wr_d         = bus.cpu_wr;
                        addr_d       = bus.cpu_address;
                        wdata_d      = bus.cpu_write_data;
                    end else begin
                        owner_d      = OWNER_LD;
                        last_owner_d = OWNER_LD;
                        wr_d         = bus.ld_wr;
                        addr_d       = bus.ld_address;
                        wdata_d      = bus.ld_write_data;
                    end
                    ram_en_d = 1'b1;
                    ram_we_d = wr_d;
                    state_d  = MEMC_ACCESS;
                end
            end
            MEMC_ACCESS: begin
                cnt_d   = WAIT_CNT;
                state_d = MEMC_WAIT;
            end
            MEMC_WAIT: begin
                // RAM data is valid during the first WAIT cycle only.
                if ((cnt_q == WAIT_CNT) && !wr_q) begin
                    rdata_d = bus.ram_rdata;
                end
                if (cnt_q == 4'd0) begin
                    state_d = MEMC_DONE;
                    if (owner_q == OWNER_CPU) begin
                        cpu_ready_d = 1'b1;
                        cpu_valid_d = !wr_q;
                    end else begin
                        ld_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MEMC_DONE: begin
                state_d = MEMC_RELEASE;
            end
            MEMC_RELEASE: begin
                // Hold until the served requester lets go, so a sticky request is not re-issued.
                if (owner_q == OWNER_CPU ? !bus.cpu_cs : !bus.ld_req) begin
                    state_d = MEMC_IDLE;
                end
            end
            default: begin
                state_d = MEMC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, and all state uses non-blocking assignment.
        if (!reset_n) begin
            state_q      <= MEMC_IDLE;
            owner_q      <= OWNER_CPU;
            last_owner_q <= OWNER_LD;
            wr_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            cnt_q        <= 4'd0;
            rdata_q      <= 8'h00;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_valid_q  <= 1'b0;
            ld_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_valid_q  <= cpu_valid_d;
            ld_ack_q     <= ld_ack_d;
        end
    end

    assign bus.cpu_mem_ready  = cpu_ready_q;
    assign bus.cpu_data_valid = cpu_valid_q;
    assign bus.cpu_read_data  = rdata_q;
    assign bus.ld_ack         = ld_ack_q;
    assign bus.ld_read_data   = rdata_q;
    assign bus.ram_en         = ram_en_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_addr       = addr_q;
    assign bus.ram_wdata      = wdata_q;

endmodule
